// File: rtl/des_round_if.sv
// des_round_if
//   Request/result handshake plus datapath strobes shared by the DES round
//   controller and whatever drives it (source, datapath, sink).
//   master : request source / datapath / result sink side
//   slave  : des_round_ctrl side
//   Signals:
//     in_valid, in_ready, in_decrypt   request handshake and direction
//     load, round_en, fin_capture      datapath strobes (one-hot or all 0)
//     round_idx[3:0]                   current round while round_en=1
//     key_shift[1:0], key_dir          C/D rotate amount and direction
//     out_valid, out_ready             result handshake
//     busy                             controller not idle
interface des_round_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_decrypt;
    logic       load;
    logic       round_en;
    logic [3:0] round_idx;
    logic [1:0] key_shift;
    logic       key_dir;
    logic       fin_capture;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    modport master (
        output in_valid, in_decrypt, out_ready,
        input  in_ready, load, round_en, round_idx, key_shift, key_dir,
               fin_capture, out_valid, busy
    );

    modport slave (
        input  in_valid, in_decrypt, out_ready,
        output in_ready, load, round_en, round_idx, key_shift, key_dir,
               fin_capture, out_valid, busy
    );
endinterface

// File: rtl/des_round_ctrl.sv
// des_round_ctrl
//   Sequencer for an iterative single-round DES datapath. Accepts one
//   encrypt/decrypt request, strobes load, NROUNDS rounds and the final
//   capture, then holds the result until the sink takes it.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   des_round_if.slave (handshakes, datapath strobes, key schedule)
//   Parameter:
//     NROUNDS  rounds per block (16 for DES, >=2 for debug builds)
//
//   state   | meaning
//   --------+--------------------------------------------------
//   S_IDLE  | waiting for a request, in_ready=1
//   S_LOAD  | datapath latches IP(data) and PC-1(key)
//   S_ROUND | one DES round per cycle, round_idx = counter
//   S_FINAL | datapath captures i_IP(R16||L16)
//   S_HOLD  | result valid, waiting for out_ready
module des_round_ctrl #(
    parameter int NROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    des_round_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_HOLD
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NROUNDS - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       dir, dir_nx;

    // Rotate amount per round. Decrypt walks the schedule backwards with
    // right rotations, so its first round uses K16 = K0 unrotated.
    function automatic logic [1:0] shift_amt(input logic [3:0] r, input logic d);
        logic [1:0] s;
        if (d && r == 4'd0)
            s = 2'd0;
        else if (r == 4'd0 || r == 4'd1 || r == 4'd8 || r == 4'd15)
            s = 2'd1;
        else
            s = 2'd2;
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            dir   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            dir   <= dir_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        dir_nx          = dir;
        bus.in_ready    = 1'b0;
        bus.load        = 1'b0;
        bus.round_en    = 1'b0;
        bus.round_idx   = 4'd0;
        bus.key_shift   = 2'd0;
        bus.key_dir     = 1'b0;
        bus.fin_capture = 1'b0;
        bus.out_valid   = 1'b0;
        bus.busy        = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    dir_nx   = bus.in_decrypt;
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.load = 1'b1;
                cnt_nx   = 4'd0;
                state_nx = S_ROUND;
            end
            S_ROUND: begin
                bus.round_en  = 1'b1;
                bus.round_idx = cnt;
                bus.key_shift = shift_amt(cnt, dir);
                bus.key_dir   = dir;
                if (cnt == LAST_ROUND) begin
                    cnt_nx   = 4'd0;
                    state_nx = S_FINAL;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            S_FINAL: begin
                bus.fin_capture = 1'b1;
                state_nx        = S_HOLD;
            end
            S_HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl
//   Self-checking bench for des_round_ctrl. Expected per-round schedule
//   entries are queued at the accept edge and popped on each round_en cycle.
module tb_des_round_ctrl;
    localparam int NR = 16;

    logic clk;
    logic rst;
    des_round_if bus ();

    des_round_ctrl #(.NROUNDS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] idx;
        logic [1:0] shift;
        logic       dir;
    } sched_t;

    sched_t sq[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] enc_tab [NR] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [1:0] dec_tab [NR] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    function automatic logic [5:0] strobes();
        return {bus.load, bus.round_en, bus.fin_capture, bus.out_valid, bus.in_ready, bus.busy};
    endfunction

    task automatic push_expected(input logic dec);
        sched_t e;
        for (int r = 0; r < NR; r++) begin
            e.idx   = 4'(r);
            e.shift = dec ? dec_tab[r] : enc_tab[r];
            e.dir   = dec;
            sq.push_back(e);
        end
    endtask

    // Presents a request at a negedge and returns just after the accept edge.
    // in_decrypt is flipped afterwards; it must not affect the block in flight.
    task automatic accept(input logic dec);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_decrypt = dec;
        @(posedge clk);
        push_expected(dec);
        #1;
        bus.in_valid   = 1'b0;
        bus.in_decrypt = ~dec;
    endtask

    // Checks cycles T+1..T+19 after an accept at T, then the hold phase.
    // stall=0 keeps out_ready high throughout (early ready must be harmless).
    // next_dec>=0 raises a new request during HOLD to test back-to-back accept.
    task automatic check_block(input int stall, input int next_dec);
        logic [5:0] exp_s;
        sched_t     e;
        sched_t     obs;
        bus.out_ready = (stall == 0);
        for (int k = 1; k <= NR + 3; k++) begin
            @(negedge clk);
            exp_s = {k == 1, (k >= 2 && k <= NR + 1), k == NR + 2, k == NR + 3, 1'b0, 1'b1};
            n_tests++;
            if (strobes() !== exp_s) begin
                n_fail++;
                $display("FAIL strobes cycle T+%0d: got %b expected %b", k, strobes(), exp_s);
            end
            obs = {bus.round_idx, bus.key_shift, bus.key_dir};
            if (bus.round_en === 1'b1) begin
                if (sq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sched_underflow cycle T+%0d: queue empty", k);
                end else begin
                    e = sq.pop_front();
                    n_tests++;
                    if (obs !== e) begin
                        n_fail++;
                        $display("FAIL sched round %0d: got idx=%0d shift=%0d dir=%b expected idx=%0d shift=%0d dir=%b",
                                 e.idx, obs.idx, obs.shift, obs.dir, e.idx, e.shift, e.dir);
                    end
                end
            end else begin
                n_tests++;
                if (obs !== '0) begin
                    n_fail++;
                    $display("FAIL sched_idle cycle T+%0d: got %b expected 0", k, obs);
                end
            end
        end
        n_tests++;
        if (sq.size() != 0) begin
            n_fail++;
            $display("FAIL sched_leftover: got %0d entries expected 0", sq.size());
            sq.delete();
        end
        if (next_dec >= 0) begin
            bus.in_valid   = 1'b1;
            bus.in_decrypt = next_dec[0];
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_tests++;
            if (strobes() !== 6'b000101) begin
                n_fail++;
                $display("FAIL hold stall %0d: got %b expected 000101", i, strobes());
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_tests++;
        if (strobes() !== 6'b000010) begin
            n_fail++;
            $display("FAIL release_idle: got %b expected 000010", strobes());
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_decrypt = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        n_tests++;
        if ({strobes(), bus.round_idx, bus.key_shift, bus.key_dir} !== {6'b000010, 7'd0}) begin
            n_fail++;
            $display("FAIL reset_values: got %b expected 0000100000000",
                     {strobes(), bus.round_idx, bus.key_shift, bus.key_dir});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++;
            if ({strobes(), bus.round_idx, bus.key_shift, bus.key_dir} !== {6'b000010, 7'd0}) begin
                n_fail++;
                $display("FAIL idle_after_reset %0d: got %b expected 0000100000000", i,
                         {strobes(), bus.round_idx, bus.key_shift, bus.key_dir});
            end
        end
    endtask

    task automatic test_encrypt();
        accept(1'b0);
        check_block(0, -1);
    endtask

    task automatic test_decrypt_stall();
        accept(1'b1);
        check_block(20, -1);
    endtask

    task automatic test_back_to_back();
        accept(1'b0);
        check_block(2, 1);
        // in_valid was left high: the IDLE cycle just checked accepts it.
        @(posedge clk);
        push_expected(1'b1);
        #1;
        bus.in_valid   = 1'b0;
        bus.in_decrypt = 1'b0;
        check_block(0, -1);
    endtask

    task automatic test_reset_mid_round();
        accept(1'b0);
        for (int k = 1; k <= 9; k++) @(negedge clk);
        n_tests++;
        if ({bus.round_en, bus.round_idx} !== {1'b1, 4'd7}) begin
            n_fail++;
            $display("FAIL mid_round_pos: got round_en=%b idx=%0d expected 1/7", bus.round_en, bus.round_idx);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if ({strobes(), bus.round_idx, bus.key_shift, bus.key_dir} !== {6'b000010, 7'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected 0000100000000",
                     {strobes(), bus.round_idx, bus.key_shift, bus.key_dir});
        end
        sq.delete();
        @(negedge clk);
        rst = 1'b0;
        accept(1'b1);
        check_block(3, -1);
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt_stall();
        test_back_to_back();
        test_reset_mid_round();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
